// File: rtl/mmio_csr_bank.sv
// CSR window for a single accelerator job: scratch, control, status, buffer address,
// length and cycle counter, plus the IDLE/RUN/DONE job FSM behind them.
module mmio_csr_bank #(
    parameter logic [15:0] BASE_ADDR = 16'h0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mmio_wr_valid,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_addr,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wr_data,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        acc_start,
    output logic        acc_abort,
    output logic [63:0] acc_buf_addr,
    output logic [31:0] acc_len,
    input  logic        acc_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OFF_SCRATCH = 4'h0;
    localparam logic [3:0] OFF_CTRL    = 4'h2;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_BUF     = 4'h6;
    localparam logic [3:0] OFF_LEN     = 4'h8;
    localparam logic [3:0] OFF_CYCLES  = 4'hA;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_scratch;
    logic [57:0] r_buf_addr;
    logic [31:0] r_len;
    logic [31:0] r_cycles;
    logic        r_err;
    logic        r_rsp_valid;
    logic [8:0]  r_rsp_tid;
    logic [63:0] r_rsp_data;
    logic        r_acc_start;
    logic        r_acc_abort;

    logic [16:0] w_off_full;
    logic [3:0]  w_off;
    logic        w_hit;
    logic        w_wr_hit;
    logic        w_rd_hit;
    logic        w_ctrl_start;
    logic        w_ctrl_abort;
    logic        w_status_rd;
    logic        w_err_next;
    logic        w_start_pulse;
    logic        w_abort_pulse;
    logic        w_clr_cycles;
    logic [63:0] w_rd_data;

    // Addresses below the base borrow into bit 16, so one compare bounds both ends.
    assign w_off_full = {1'b0, mmio_addr} - {1'b0, BASE_ADDR};
    assign w_off      = w_off_full[3:0];
    assign w_hit      = (w_off_full <= 17'd10) && !mmio_addr[0];
    assign w_wr_hit   = mmio_wr_valid && w_hit;
    assign w_rd_hit   = mmio_rd_valid && w_hit;

    assign w_ctrl_abort = w_wr_hit && (w_off == OFF_CTRL) && mmio_wr_data[1];
    assign w_ctrl_start = w_wr_hit && (w_off == OFF_CTRL) && mmio_wr_data[0] && !mmio_wr_data[1];
    assign w_status_rd  = w_rd_hit && (w_off == OFF_STATUS);

    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_SCRATCH: w_rd_data = r_scratch;
            OFF_STATUS:  w_rd_data = {61'b0, r_err, r_state == ST_DONE, r_state == ST_RUN};
            OFF_BUF:     w_rd_data = {r_buf_addr, 6'b0};
            OFF_LEN:     w_rd_data = {32'b0, r_len};
            OFF_CYCLES:  w_rd_data = {32'b0, r_cycles};
            default:     w_rd_data = '0;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_err_next    = r_err;
        w_start_pulse = 1'b0;
        w_abort_pulse = 1'b0;
        w_clr_cycles  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_ctrl_start) begin
                    if (r_len != 32'd0) begin
                        w_state_next  = ST_RUN;
                        w_start_pulse = 1'b1;
                        w_clr_cycles  = 1'b1;
                        w_err_next    = 1'b0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end else if (r_state == ST_DONE && w_status_rd) begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_ctrl_abort) begin
                    w_state_next  = ST_IDLE;
                    w_abort_pulse = 1'b1;
                end else begin
                    if (w_ctrl_start) begin
                        w_err_next = 1'b1;
                    end
                    if (acc_done) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_scratch   <= '0;
            r_buf_addr  <= '0;
            r_len       <= '0;
            r_cycles    <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_tid   <= '0;
            r_rsp_data  <= '0;
            r_acc_start <= 1'b0;
            r_acc_abort <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_err       <= w_err_next;
            r_acc_start <= w_start_pulse;
            r_acc_abort <= w_abort_pulse;
            r_rsp_valid <= w_rd_hit;
            if (w_rd_hit) begin
                r_rsp_tid  <= mmio_tid;
                r_rsp_data <= w_rd_data;
            end
            if (w_wr_hit && w_off == OFF_SCRATCH) begin
                r_scratch <= mmio_wr_data;
            end
            // Job parameters are frozen while the accelerator is consuming them.
            if (w_wr_hit && w_off == OFF_BUF && r_state != ST_RUN) begin
                r_buf_addr <= mmio_wr_data[63:6];
            end
            if (w_wr_hit && w_off == OFF_LEN && r_state != ST_RUN) begin
                r_len <= mmio_wr_data[31:0];
            end
            if (w_clr_cycles) begin
                r_cycles <= '0;
            end else if (r_state == ST_RUN && r_cycles != 32'hFFFF_FFFF) begin
                r_cycles <= r_cycles + 32'd1;
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_tid      = r_rsp_tid;
    assign rsp_data     = r_rsp_data;
    assign acc_start    = r_acc_start;
    assign acc_abort    = r_acc_abort;
    assign acc_buf_addr = {r_buf_addr, 6'b0};
    assign acc_len      = r_len;

endmodule

// File: tb/tb_mmio_csr_bank.sv
// Directed bench for mmio_csr_bank: register map vectors from a table, then
// hand-written job FSM and reset sequences.
module tb_mmio_csr_bank;

    localparam logic [15:0] A_SCRATCH = 16'h0010;
    localparam logic [15:0] A_CTRL    = 16'h0012;
    localparam logic [15:0] A_STATUS  = 16'h0014;
    localparam logic [15:0] A_BUF     = 16'h0016;
    localparam logic [15:0] A_LEN     = 16'h0018;
    localparam logic [15:0] A_CYCLES  = 16'h001A;

    logic        clk;
    logic        rst_n;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wr_data;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        acc_start;
    logic        acc_abort;
    logic [63:0] acc_buf_addr;
    logic [31:0] acc_len;
    logic        acc_done;

    int n_chk;
    int n_err;
    int start_cnt;
    int abort_cnt;

    mmio_csr_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mmio_wr_valid(mmio_wr_valid),
        .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr    (mmio_addr),
        .mmio_tid     (mmio_tid),
        .mmio_wr_data (mmio_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_tid      (rsp_tid),
        .rsp_data     (rsp_data),
        .acc_start    (acc_start),
        .acc_abort    (acc_abort),
        .acc_buf_addr (acc_buf_addr),
        .acc_len      (acc_len),
        .acc_done     (acc_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulses last one full clock, so sampling on the falling edge counts each once.
    initial begin
        start_cnt = 0;
        abort_cnt = 0;
        forever begin
            @(negedge clk);
            if (acc_start) start_cnt++;
            if (acc_abort) abort_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [8:0]  tid;
        logic [63:0] data;
        logic        exp_valid;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [15:0] addr, input logic [63:0] data);
        mmio_wr_valid = 1'b1;
        mmio_addr     = addr;
        mmio_wr_data  = data;
        tick();
        mmio_wr_valid = 1'b0;
        $display("wr addr=%h data=%h", addr, data);
    endtask

    task automatic do_rd(input logic [15:0] addr, input logic [8:0] tid,
                         output logic v, output logic [8:0] t, output logic [63:0] d);
        mmio_rd_valid = 1'b1;
        mmio_addr     = addr;
        mmio_tid      = tid;
        tick();
        mmio_rd_valid = 1'b0;
        v = rsp_valid;
        t = rsp_tid;
        d = rsp_data;
        $display("rd addr=%h tid=%h -> valid=%b tid=%h data=%h", addr, tid, v, t, d);
    endtask

    task automatic rd_check(input string name, input logic [15:0] addr, input logic [63:0] exp);
        logic        v;
        logic [8:0]  t;
        logic [63:0] d;
        do_rd(addr, 9'h0AA, v, t, d);
        check({name, "_valid"}, 64'(v), 64'd1);
        check({name, "_data"}, d, exp);
    endtask

    initial begin
        logic        v;
        logic [8:0]  t;
        logic [63:0] d;
        int          s0;
        int          a0;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        mmio_addr = '0;
        mmio_tid = '0;
        mmio_wr_data = '0;
        acc_done = 1'b0;

        vecs[0]  = '{1'b1, A_SCRATCH, 9'h000, 64'hDEADBEEF_01234567, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, A_SCRATCH, 9'h005, 64'h0, 1'b1, 64'hDEADBEEF_01234567};
        vecs[2]  = '{1'b1, A_BUF,     9'h000, 64'h1234_5678_9ABC_DEFF, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, A_BUF,     9'h01A, 64'h0, 1'b1, 64'h1234_5678_9ABC_DEC0};
        vecs[4]  = '{1'b1, A_LEN,     9'h000, 64'hFFFF_FFFF_0000_0004, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, A_LEN,     9'h1FF, 64'h0, 1'b1, 64'h0000_0000_0000_0004};
        vecs[6]  = '{1'b0, A_CTRL,    9'h012, 64'h0, 1'b1, 64'h0};
        vecs[7]  = '{1'b0, A_STATUS,  9'h100, 64'h0, 1'b1, 64'h0};
        vecs[8]  = '{1'b0, A_CYCLES,  9'h033, 64'h0, 1'b1, 64'h0};
        vecs[9]  = '{1'b0, 16'h001C,  9'h001, 64'h0, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 16'h0011,  9'h002, 64'h0, 1'b0, 64'h0};
        vecs[11] = '{1'b1, 16'h0011,  9'h000, 64'h5555_5555_5555_5555, 1'b0, 64'h0};
        vecs[12] = '{1'b1, 16'h000E,  9'h000, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h0};
        vecs[13] = '{1'b0, A_SCRATCH, 9'h0C3, 64'h0, 1'b1, 64'hDEADBEEF_01234567};
        vecs[14] = '{1'b0, 16'h000F,  9'h004, 64'h0, 1'b0, 64'h0};
        vecs[15] = '{1'b0, 16'hFFF0,  9'h008, 64'h0, 1'b0, 64'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_acc_start", 64'(acc_start), 64'd0);
        check("rst_acc_abort", 64'(acc_abort), 64'd0);
        check("rst_buf_addr", acc_buf_addr, 64'd0);
        check("rst_len", 64'(acc_len), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                do_wr(vecs[i].addr, vecs[i].data);
            end else begin
                do_rd(vecs[i].addr, vecs[i].tid, v, t, d);
                check($sformatf("vec%0d_valid", i), 64'(v), 64'(vecs[i].exp_valid));
                if (vecs[i].exp_valid) begin
                    check($sformatf("vec%0d_tid", i), 64'(t), 64'(vecs[i].tid));
                    check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
                end
            end
        end
        check("buf_addr_out", acc_buf_addr, 64'h1234_5678_9ABC_DEC0);
        check("len_out", 64'(acc_len), 64'd4);

        // Simultaneous write and read of SCRATCH: read sees the old value
        mmio_wr_valid = 1'b1;
        mmio_rd_valid = 1'b1;
        mmio_addr     = A_SCRATCH;
        mmio_wr_data  = 64'h0000_0000_0000_1111;
        mmio_tid      = 9'h003;
        tick();
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        check("rdwr_valid", 64'(rsp_valid), 64'd1);
        check("rdwr_old_data", rsp_data, 64'hDEADBEEF_01234567);
        tick();
        check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        rd_check("rdwr_new", A_SCRATCH, 64'h1111);

        // Full job: LEN=4, start, 10 cycles in RUN, done, clear-on-read
        s0 = start_cnt;
        do_wr(A_CTRL, 64'h1);
        check("job_start_pulse", 64'(acc_start), 64'd1);
        tick();
        check("job_start_once", 64'(acc_start), 64'd0);
        repeat (2) tick();
        rd_check("job_status_run", A_STATUS, 64'h1);
        do_wr(A_LEN, 64'h7);
        repeat (4) tick();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        rd_check("job_status_done", A_STATUS, 64'h2);
        rd_check("job_status_cleared", A_STATUS, 64'h0);
        rd_check("job_cycles", A_CYCLES, 64'd10);
        rd_check("job_len_frozen", A_LEN, 64'd4);
        check("job_start_count", 64'(start_cnt - s0), 64'd1);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        rd_check("done_in_idle", A_STATUS, 64'h0);

        // LEN==0 start sets err; abort+start in RUN aborts cleanly
        do_wr(A_LEN, 64'h0);
        s0 = start_cnt;
        do_wr(A_CTRL, 64'h1);
        check("len0_no_start", 64'(acc_start), 64'd0);
        rd_check("len0_status", A_STATUS, 64'h4);
        check("len0_start_count", 64'(start_cnt - s0), 64'd0);
        do_wr(A_LEN, 64'h1);
        do_wr(A_CTRL, 64'h1);
        check("len1_start", 64'(acc_start), 64'd1);
        rd_check("len1_status_run", A_STATUS, 64'h1);
        a0 = abort_cnt;
        do_wr(A_CTRL, 64'h3);
        check("abort_pulse", 64'(acc_abort), 64'd1);
        check("abort_no_start", 64'(acc_start), 64'd0);
        rd_check("abort_status", A_STATUS, 64'h0);
        check("abort_count", 64'(abort_cnt - a0), 64'd1);

        // acc_done together with STATUS read in RUN
        do_wr(A_CTRL, 64'h1);
        tick();
        acc_done = 1'b1;
        rd_check("done_rd_same", A_STATUS, 64'h1);
        acc_done = 1'b0;
        rd_check("done_rd_after", A_STATUS, 64'h2);
        rd_check("done_rd_clear", A_STATUS, 64'h0);

        // Start while RUN sets err; abort beats a coincident acc_done
        do_wr(A_CTRL, 64'h1);
        do_wr(A_CTRL, 64'h1);
        rd_check("run_start_err", A_STATUS, 64'h5);
        acc_done = 1'b1;
        do_wr(A_CTRL, 64'h2);
        acc_done = 1'b0;
        check("abort_vs_done_pulse", 64'(acc_abort), 64'd1);
        rd_check("abort_vs_done_status", A_STATUS, 64'h4);

        // Reset mid-RUN with a read request pending
        do_wr(A_CTRL, 64'h1);
        rd_check("pre_reset_run", A_STATUS, 64'h1);
        mmio_rd_valid = 1'b1;
        mmio_addr     = A_STATUS;
        mmio_tid      = 9'h007;
        #3;
        rst_n = 1'b0;
        a0 = abort_cnt;
        #1;
        check("arst_buf_addr", acc_buf_addr, 64'd0);
        check("arst_len", 64'(acc_len), 64'd0);
        check("arst_rsp_tid", 64'(rsp_tid), 64'd0);
        tick();
        mmio_rd_valid = 1'b0;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_rsp_data", rsp_data, 64'd0);
        check("arst_abort", 64'(acc_abort), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_no_response", 64'(rsp_valid), 64'd0);
        check("arst_abort_count", 64'(abort_cnt - a0), 64'd0);
        rd_check("post_rst_status", A_STATUS, 64'h0);
        rd_check("post_rst_scratch", A_SCRATCH, 64'h0);
        rd_check("post_rst_cycles", A_CYCLES, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
